flash_blink_ctrl: RTL and testbench

- Consumer end of the flash-rate divider: takes its single-cycle 5 Hz tick strobe (en_nxt) and turns it into display blink controls.
- Outputs are a cursor-visible flag and a half-rate attribute-blink flag.
- Phase changes are deferred to the next vertical-sync rising edge, so a blink never toggles mid-frame (no tearing).
- Sits between the flash tick divider and the VGA pixel/attribute path.

---
 rtl/flash_blink_ctrl_pkg.sv | 8 +
 rtl/flash_blink_ctrl_rise_det.sv | 16 +
 rtl/flash_blink_ctrl.sv | 125 ++++++++++++
 tb/tb_flash_blink_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/flash_blink_ctrl_pkg.sv
// Shared types and defaults for the flash blink controller.
package flash_pkg;
    typedef enum logic [1:0] {IDLE, ON, OFF} blink_state_t;

    localparam int DEF_ON_TICKS  = 3;
    localparam int DEF_OFF_TICKS = 2;
    localparam int MISSED_W      = 8;
endpackage

// File: rtl/flash_blink_ctrl_rise_det.sv
// Registered rising-edge detector: rise is high while sig is high and was low the previous cycle.
module rise_det (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic rise
);
    logic sig_d;

    always_ff @(posedge clk) begin
        if (reset) sig_d <= 1'b0;
        else       sig_d <= sig;
    end

    assign rise = sig & ~sig_d;
endmodule

// File: rtl/flash_blink_ctrl.sv
// Cursor / attribute blink controller; phase flips are deferred to the next vsync rising edge.
// Optional dropped-tick counter on output missed_ticks when FLASH_BLINK_STATUS_EN is defined.
module flash_blink_ctrl
    import flash_pkg::*;
#(
    parameter int ON_TICKS  = DEF_ON_TICKS,
    parameter int OFF_TICKS = DEF_OFF_TICKS,
    parameter int CNT_W     = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en_nxt,
    input  logic vsync,
    input  logic enable,
    input  logic force_on,
    output logic cursor_vis,
    output logic attr_vis,
    output logic phase_chg
`ifdef FLASH_BLINK_STATUS_EN
    ,
    output logic [MISSED_W-1:0] missed_ticks
`endif
);
    localparam logic [CNT_W-1:0] ON_TC  = CNT_W'(ON_TICKS);
    localparam logic [CNT_W-1:0] OFF_TC = CNT_W'(OFF_TICKS);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    blink_state_t     state, state_nxt;
    logic [CNT_W-1:0] tick_cnt, cnt_nxt, term, new_term;
    logic             pending, pend_nxt;
    logic             attr_q, attr_nxt, chg_nxt, cursor_q;
    logic             vs_rise;

    rise_det u_vs_rise (
        .clk   (clk),
        .reset (reset),
        .sig   (vsync),
        .rise  (vs_rise)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = tick_cnt;
        pend_nxt  = pending;
        attr_nxt  = attr_q;
        chg_nxt   = 1'b0;
        term      = (state == ON) ? ON_TC : OFF_TC;
        new_term  = (state == ON) ? OFF_TC : ON_TC;
        if (!enable) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            pend_nxt  = 1'b0;
            attr_nxt  = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = ON;
                    cnt_nxt   = '0;
                    pend_nxt  = 1'b0;
                    attr_nxt  = 1'b1;
                end
                ON, OFF: begin
                    if (vs_rise && pending) begin
                        state_nxt = (state == ON) ? OFF : ON;
                        chg_nxt   = 1'b1;
                        if (state == OFF) attr_nxt = ~attr_q;
                        // A coincident tick is the first tick of the new phase.
                        cnt_nxt  = en_nxt ? ONE : '0;
                        pend_nxt = en_nxt && (new_term == ONE);
                    end else if (en_nxt && !pending) begin
                        if (tick_cnt + ONE == term) begin
                            cnt_nxt  = term;
                            pend_nxt = 1'b1;
                        end else begin
                            cnt_nxt = tick_cnt + ONE;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    pend_nxt  = 1'b0;
                    attr_nxt  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            pending   <= 1'b0;
            attr_q    <= 1'b1;
            phase_chg <= 1'b0;
            cursor_q  <= 1'b1;
        end else begin
            state     <= state_nxt;
            tick_cnt  <= cnt_nxt;
            pending   <= pend_nxt;
            attr_q    <= attr_nxt;
            phase_chg <= chg_nxt;
            // Registered from the next state so the flip lands one cycle after vs_rise.
            cursor_q  <= (state_nxt != OFF);
        end
    end

    assign cursor_vis = cursor_q | force_on;
    assign attr_vis   = attr_q;

`ifdef FLASH_BLINK_STATUS_EN
    logic [MISSED_W-1:0] missed_q;
    logic                drop;

    // pending is only ever set in ON/OFF, and a vs_rise with pending consumes the tick.
    assign drop = enable & en_nxt & pending & ~vs_rise;

    always_ff @(posedge clk) begin
        if (reset || !enable)           missed_q <= '0;
        else if (drop && missed_q != '1) missed_q <= missed_q + 1'b1;
    end

    assign missed_ticks = missed_q;
`endif
endmodule

// File: tb/tb_flash_blink_ctrl.sv
// Directed plus random bench for flash_blink_ctrl against a tick-counting reference model.
module tb_flash_blink_ctrl;
    localparam int ON_T  = 3;
    localparam int OFF_T = 2;

    logic clk = 1'b0;
    logic reset, en_nxt, vsync, enable, force_on;
    logic cursor_vis, attr_vis, phase_chg;
`ifdef FLASH_BLINK_STATUS_EN
    logic [7:0] missed_ticks;
`endif

    flash_blink_ctrl #(.ON_TICKS(ON_T), .OFF_TICKS(OFF_T), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .en_nxt     (en_nxt),
        .vsync      (vsync),
        .enable     (enable),
        .force_on   (force_on),
        .cursor_vis (cursor_vis),
        .attr_vis   (attr_vis),
        .phase_chg  (phase_chg)
`ifdef FLASH_BLINK_STATUS_EN
        ,
        .missed_ticks(missed_ticks)
`endif
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    bit fo       = 1'b0;

    // Reference: mode 0=idle 1=visible 2=hidden; a phase is "full" once its tick count reaches its length.
    int m_mode = 0, m_ticks = 0, m_missed = 0;
    bit m_vsd = 1'b0, m_cur = 1'b1, m_attr = 1'b1, m_pc = 1'b0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model(input bit r, input bit e, input bit v, input bit en);
        bit rise, full;
        int need;
        rise  = v && !m_vsd;
        m_vsd = r ? 1'b0 : v;
        m_pc  = 1'b0;
        if (r) begin
            m_mode = 0; m_ticks = 0; m_attr = 1'b1; m_missed = 0;
        end else if (!en) begin
            m_mode = 0; m_ticks = 0; m_attr = 1'b1; m_missed = 0;
        end else if (m_mode == 0) begin
            m_mode = 1; m_ticks = 0;
        end else begin
            need = (m_mode == 1) ? ON_T : OFF_T;
            full = (m_ticks >= need);
            if (rise && full) begin
                if (m_mode == 2) m_attr = !m_attr;
                m_mode  = 3 - m_mode;
                m_ticks = e ? 1 : 0;
                m_pc    = 1'b1;
            end else if (e) begin
                if (full) m_missed = (m_missed < 255) ? m_missed + 1 : 255;
                else      m_ticks++;
            end
        end
        m_cur = (m_mode != 2);
    endtask

    task automatic step(input bit r, input bit e, input bit v, input bit en);
        reset = r; en_nxt = e; vsync = v; enable = en; force_on = fo;
        @(posedge clk);
        model(r, e, v, en);
        #1;
        chk("cursor_vis", 8'(cursor_vis), 8'(m_cur | fo));
        chk("attr_vis", 8'(attr_vis), 8'(m_attr));
        chk("phase_chg", 8'(phase_chg), 8'(m_pc));
`ifdef FLASH_BLINK_STATUS_EN
        chk("missed_ticks", missed_ticks, 8'(m_missed));
`endif
    endtask

    task automatic run(input int cycles, input int tper, input int vper);
        for (int c = 0; c < cycles; c++)
            step(1'b0, (tper > 0) && (c % tper == tper - 1), (vper > 0) && (c % vper < 2), 1'b1);
    endtask

    task automatic restart();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; en_nxt = 1'b0; vsync = 1'b0; enable = 1'b1; force_on = 1'b0;
        // 1. reset and enable
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("rst_cursor", 8'(cursor_vis), 8'd1);
        chk("rst_attr", 8'(attr_vis), 8'd1);
        chk("rst_phase_chg", 8'(phase_chg), 8'd0);
        run(60, 20, 0);
        chk("t1_pending_cursor", 8'(cursor_vis), 8'd1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("t1_flip_pc", 8'(phase_chg), 8'd1);
        chk("t1_flip_cursor", 8'(cursor_vis), 8'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t1_pc_pulse", 8'(phase_chg), 8'd0);
        run(40, 20, 0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("t1_on_cursor", 8'(cursor_vis), 8'd1);
        chk("t1_on_attr", 8'(attr_vis), 8'd0);
        run(140, 20, 7);

        // 2. deferred update
        restart();
        run(60, 20, 0);
        run(100, 0, 0);
        run(100, 20, 0);
        chk("t2_held_cursor", 8'(cursor_vis), 8'd1);
`ifdef FLASH_BLINK_STATUS_EN
        chk("t2_missed", missed_ticks, 8'd5);
`endif
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("t2_flip_cursor", 8'(cursor_vis), 8'd0);

        // 3. simultaneous tick and vsync edge
        restart();
        run(60, 20, 0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("t3_flip_cursor", 8'(cursor_vis), 8'd0);
        chk("t3_flip_pc", 8'(phase_chg), 8'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("t3_back_on_pc", 8'(phase_chg), 8'd1);
        chk("t3_back_on_cursor", 8'(cursor_vis), 8'd1);

        // 4. disable mid-pending
        restart();
        run(60, 20, 0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        run(40, 20, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_idle_cursor", 8'(cursor_vis), 8'd1);
        chk("t4_idle_attr", 8'(attr_vis), 8'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t4_no_pc", 8'(phase_chg), 8'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // 5. force_on while hidden
        restart();
        run(60, 20, 0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        fo = 1'b1; force_on = 1'b1;
        #1;
        chk("t5_force_same_cycle", 8'(cursor_vis), 8'd1);
        run(40, 20, 0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("t5_force_pc", 8'(phase_chg), 8'd1);
        chk("t5_force_attr", 8'(attr_vis), 8'd0);
        fo = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // 6. dropped-tick saturation
        restart();
        run(60, 20, 0);
        run(600, 2, 0);
`ifdef FLASH_BLINK_STATUS_EN
        chk("t6_saturated", missed_ticks, 8'd255);
`endif
        step(1'b1, 1'b0, 1'b0, 1'b1);
`ifdef FLASH_BLINK_STATUS_EN
        chk("t6_cleared", missed_ticks, 8'd0);
`endif
        chk("t6_reset_cursor", 8'(cursor_vis), 8'd1);

        // random traffic
        begin
            bit v = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 5) == 0) v = !v;
                fo = ($urandom_range(0, 9) == 0);
                step($urandom_range(0, 499) == 0, $urandom_range(0, 3) == 0, v,
                     $urandom_range(0, 199) != 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
